// File: rtl/mips_irq_ctrl.sv
// mips_irq_ctrl: N-channel synchronised, fixed-priority interrupt controller feeding CP0
// Lowest channel index wins; one interrupt in service at a time, released by irq_done.
module mips_irq_ctrl #(
  parameter int N_IRQ = 8,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             global_ie,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             irq_busy,
  input  logic             cfg_wen,
  input  logic [1:0]       cfg_addr,
  input  logic [N_IRQ-1:0] cfg_wdata,
  output logic [N_IRQ-1:0] cfg_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state;
  logic [N_IRQ-1:0] sq [SYNC_STAGES];
  logic [N_IRQ-1:0] s, prev, en, mode, pend, pend_n, clr, eff, id_mask;
  logic [ID_W-1:0] sel;
  assign s = sq[SYNC_STAGES-1];
  assign eff = pend & en;
  assign id_mask = N_IRQ'(1) << irq_id;
  assign clr = (cfg_wen && cfg_addr == 2'd2 ? cfg_wdata : '0) |
               (state == REQ && irq_ack ? id_mask : '0);
  // a fresh edge wins over any clear landing in the same cycle
  assign pend_n = (mode & s) | (~mode & ((s & ~prev) | (pend & ~clr)));
  assign cfg_rdata = cfg_addr == 2'd0 ? en :
                     cfg_addr == 2'd1 ? mode :
                     cfg_addr == 2'd2 ? pend : s;
  always_comb begin
    sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (eff[i]) sel = ID_W'(i);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sq[k] <= '0;
      prev <= '0;
      en <= '0;
      mode <= '0;
      pend <= '0;
    end else begin
      sq[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) sq[k] <= sq[k-1];
      prev <= s;
      pend <= pend_n;
      if (cfg_wen && cfg_addr == 2'd0) en <= cfg_wdata;
      if (cfg_wen && cfg_addr == 2'd1) mode <= cfg_wdata;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      irq_req <= 1'b0;
      irq_id <= '0;
      irq_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (global_ie && |eff) begin
          irq_id <= sel;
          irq_req <= 1'b1;
          state <= REQ;
        end
        REQ: if (irq_ack) begin
          irq_req <= 1'b0;
          irq_busy <= 1'b1;
          state <= SERVICE;
        end else if (!(|(eff & id_mask)) || !global_ie) begin
          irq_req <= 1'b0;
          state <= IDLE;
        end
        SERVICE: if (irq_done) begin
          irq_busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_irq_ctrl.sv
// tb_mips_irq_ctrl: vector table for edge/priority handshakes plus directed corner sequences
module tb_mips_irq_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] irq_in = '0, cfg_wdata = '0, cfg_rdata;
  logic global_ie = 1'b0, irq_ack = 1'b0, irq_done = 1'b0, cfg_wen = 1'b0;
  logic [1:0] cfg_addr = 2'd2;
  logic irq_req, irq_busy;
  logic [2:0] irq_id;
  int checks = 0, failures = 0;
  typedef struct {
    logic [7:0] irq;
    logic ack, done, req;
    logic [2:0] id;
    logic busy;
    logic [7:0] pend;
  } vec_t;
  vec_t tbl [18];
  always #5 clk = ~clk;
  mips_irq_ctrl #(.N_IRQ(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .global_ie(global_ie),
    .irq_req(irq_req), .irq_id(irq_id), .irq_ack(irq_ack), .irq_done(irq_done),
    .irq_busy(irq_busy), .cfg_wen(cfg_wen), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
  );
  function automatic vec_t v(logic [7:0] irq, logic ack, logic done, logic req,
                             logic [2:0] id, logic busy, logic [7:0] pend);
    v = '{irq, ack, done, req, id, busy, pend};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_wen = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick();
    cfg_wen = 1'b0;
    cfg_addr = 2'd2;
  endtask
  task automatic rd(input string name, input logic [1:0] a, input logic [7:0] exp);
    cfg_addr = a;
    #1;
    chk(name, cfg_rdata, exp);
    cfg_addr = 2'd2;
  endtask
  initial begin
    tbl = '{
      v(8'h08, 0, 0, 0, 0, 0, 8'h00), v(8'h00, 0, 0, 0, 0, 0, 8'h00),
      v(8'h00, 0, 0, 0, 0, 0, 8'h08), v(8'h00, 0, 0, 1, 3, 0, 8'h08),
      v(8'h00, 1, 0, 0, 0, 1, 8'h00), v(8'h00, 0, 0, 0, 0, 1, 8'h00),
      v(8'h00, 0, 1, 0, 0, 0, 8'h00), v(8'h00, 0, 0, 0, 0, 0, 8'h00),
      v(8'h24, 0, 0, 0, 0, 0, 8'h00), v(8'h00, 0, 0, 0, 0, 0, 8'h00),
      v(8'h00, 0, 0, 0, 0, 0, 8'h24), v(8'h00, 0, 0, 1, 2, 0, 8'h24),
      v(8'h00, 1, 0, 0, 0, 1, 8'h20), v(8'h00, 0, 1, 0, 0, 0, 8'h20),
      v(8'h00, 0, 0, 1, 5, 0, 8'h20), v(8'h00, 1, 0, 0, 0, 1, 8'h00),
      v(8'h00, 0, 1, 0, 0, 0, 8'h00), v(8'h00, 0, 0, 0, 0, 0, 8'h00)
    };
    repeat (2) tick();
    chk("rst_req", irq_req, 0);
    chk("rst_id", irq_id, 0);
    chk("rst_busy", irq_busy, 0);
    rd("rst_en", 2'd0, 8'h00);
    rd("rst_mode", 2'd1, 8'h00);
    rd("rst_pend", 2'd2, 8'h00);
    rd("rst_raw", 2'd3, 8'h00);
    rst = 1'b1;
    tick();
    wr(2'd0, 8'h2C);
    global_ie = 1'b1;
    for (int i = 0; i < 18; i++) begin
      irq_in = tbl[i].irq;
      irq_ack = tbl[i].ack;
      irq_done = tbl[i].done;
      tick();
      chk($sformatf("vec%0d_req", i), irq_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("vec%0d_id", i), irq_id, tbl[i].id);
      chk($sformatf("vec%0d_busy", i), irq_busy, tbl[i].busy);
      chk($sformatf("vec%0d_pend", i), cfg_rdata, tbl[i].pend);
    end
    irq_in = '0; irq_ack = 1'b0; irq_done = 1'b0;
    // level channel 1: re-request after done, withdrawal after the source drops
    wr(2'd1, 8'h02);
    wr(2'd0, 8'h2E);
    irq_in[1] = 1'b1;
    repeat (3) tick();
    chk("lvl_early", irq_req, 0);
    tick();
    chk("lvl_req", irq_req, 1);
    chk("lvl_id", irq_id, 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("lvl_ack_busy", irq_busy, 1);
    chk("lvl_ack_pend", cfg_rdata, 8'h02);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    chk("lvl_done_busy", irq_busy, 0);
    chk("lvl_done_req", irq_req, 0);
    tick();
    chk("lvl_rereq", irq_req, 1);
    chk("lvl_rereq_id", irq_id, 1);
    irq_in[1] = 1'b0;
    repeat (2) tick();
    chk("lvl_drop_hold", irq_req, 1);
    repeat (2) tick();
    chk("lvl_withdrawn", irq_req, 0);
    chk("lvl_pend_clr", cfg_rdata, 8'h00);
    wr(2'd1, 8'h00);
    // masked edge on ch0, then set-beats-clear and W1C withdrawal
    irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
    repeat (3) tick();
    chk("mask_req", irq_req, 0);
    chk("mask_pend", cfg_rdata, 8'h01);
    wr(2'd0, 8'h2F);
    chk("en_wr_req", irq_req, 0);
    tick();
    chk("en_req", irq_req, 1);
    chk("en_id", irq_id, 0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("ch0_ack_pend", cfg_rdata, 8'h00);
    chk("ch0_ack_busy", irq_busy, 1);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    chk("ch0_done_busy", irq_busy, 0);
    irq_in[0] = 1'b1; tick(); irq_in[0] = 1'b0;
    tick();
    wr(2'd2, 8'h01);
    chk("set_beats_clr", cfg_rdata, 8'h01);
    tick();
    chk("sbc_req", irq_req, 1);
    wr(2'd2, 8'h01);
    chk("w1c_pend", cfg_rdata, 8'h00);
    chk("w1c_req_hold", irq_req, 1);
    tick();
    chk("w1c_withdrawn", irq_req, 0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("stray_ack", irq_busy, 0);
    // global enable gating, withdrawal on ie drop, async reset in SERVICE
    wr(2'd0, 8'h3F);
    global_ie = 1'b0;
    irq_in[4] = 1'b1; tick(); irq_in[4] = 1'b0;
    repeat (5) tick();
    chk("ie0_req", irq_req, 0);
    chk("ie0_pend", cfg_rdata, 8'h10);
    global_ie = 1'b1; tick();
    chk("ie1_req", irq_req, 1);
    chk("ie1_id", irq_id, 4);
    global_ie = 1'b0; tick();
    chk("ie_drop_req", irq_req, 0);
    chk("ie_drop_pend", cfg_rdata, 8'h10);
    global_ie = 1'b1; tick();
    chk("ie_rereq", irq_req, 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("svc_busy", irq_busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", irq_busy, 0);
    chk("arst_req", irq_req, 0);
    chk("arst_pend", cfg_rdata, 8'h00);
    rd("arst_en", 2'd0, 8'h00);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_req", irq_req, 0);
    chk("post_rst_busy", irq_busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
